// File: rtl/rcas_seq_ctrl.sv
// Multi-cycle ripple-carry add/sub sequencer: one SLICE-bit slice per clock, LSB first,
// with the inter-slice carry held in a register. Start/busy/done handshake.
module rcas_seq_ctrl #(
  parameter int WIDTH = 32,
  parameter int SLICE = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sel,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             c_out,
  output logic             overflow
);

  localparam int N     = WIDTH / SLICE;
  localparam int IDX_W = $clog2(N + 1);
  localparam logic [IDX_W-1:0] LAST = IDX_W'(N - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t           state_q;
  logic [IDX_W-1:0] idx_q;
  logic             carry_q;
  logic             sel_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] result_q;
  logic             c_out_q;
  logic             ovf_q;
  logic             done_q;
  logic             busy_q;

  logic [SLICE-1:0] a_sl;
  logic [SLICE-1:0] b_sl;
  logic [SLICE-1:0] s_d;
  logic             c_d;
  logic             ovf_d;

  // One slice of the adder; inv turns it into a subtractor stage.
  function automatic logic [SLICE:0] slice_add(input logic [SLICE-1:0] x,
                                               input logic [SLICE-1:0] y,
                                               input logic             inv,
                                               input logic             cin);
    slice_add = {1'b0, x} + {1'b0, y ^ {SLICE{inv}}} + {{SLICE{1'b0}}, cin};
  endfunction

  always_comb begin
    a_sl = '0;
    b_sl = '0;
    for (int j = 0; j < N; j++) begin
      if (idx_q == IDX_W'(j)) begin
        a_sl = a_q[j*SLICE +: SLICE];
        b_sl = b_q[j*SLICE +: SLICE];
      end
    end
    {c_d, s_d} = slice_add(a_sl, b_sl, sel_q, carry_q);
    // Carry into the slice MSB recovered from its sum bit, then XORed with carry out.
    ovf_d = (s_d[SLICE-1] ^ a_sl[SLICE-1] ^ b_sl[SLICE-1] ^ sel_q) ^ c_d;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      idx_q    <= '0;
      carry_q  <= 1'b0;
      sel_q    <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      result_q <= '0;
      c_out_q  <= 1'b0;
      ovf_q    <= 1'b0;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE, S_DONE: begin
          if (start) begin
            a_q      <= a;
            b_q      <= b;
            sel_q    <= sel;
            carry_q  <= sel;
            idx_q    <= '0;
            result_q <= '0;
            c_out_q  <= 1'b0;
            ovf_q    <= 1'b0;
            busy_q   <= 1'b1;
            state_q  <= S_RUN;
          end else begin
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end
        end
        S_RUN: begin
          for (int j = 0; j < N; j++) begin
            if (idx_q == IDX_W'(j)) result_q[j*SLICE +: SLICE] <= s_d;
          end
          carry_q <= c_d;
          idx_q   <= idx_q + IDX_W'(1);
          if (idx_q == LAST) begin
            c_out_q <= c_d;
            ovf_q   <= ovf_d;
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= S_DONE;
          end
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign result   = result_q;
  assign c_out    = c_out_q;
  assign overflow = ovf_q;

endmodule

// File: tb/tb_rcas_seq_ctrl.sv
// Directed and randomized bench for rcas_seq_ctrl, checked against an arithmetic reference model.
module tb_rcas_seq_ctrl;

  localparam int WIDTH = 32;
  localparam int SLICE = 8;
  localparam int N     = WIDTH / SLICE;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [31:0] a;
  logic [31:0] b;
  logic        sel;
  logic        busy;
  logic        done;
  logic [31:0] result;
  logic        c_out;
  logic        overflow;

  int errors = 0;
  int checks = 0;

  logic [31:0] er;
  logic        eco;
  logic        eov;

  rcas_seq_ctrl #(.WIDTH(WIDTH), .SLICE(SLICE)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .a        (a),
    .b        (b),
    .sel      (sel),
    .busy     (busy),
    .done     (done),
    .result   (result),
    .c_out    (c_out),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference: plain integer arithmetic on the whole word.
  function automatic void model(input logic [31:0] x, input logic [31:0] y, input logic s,
                                output logic [31:0] r, output logic co, output logic ov);
    longint sx;
    longint sy;
    longint ss;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    if (s) begin
      r  = x - y;
      co = (x >= y);
      ss = sx - sy;
    end else begin
      r  = x + y;
      co = ({32'b0, x} + {32'b0, y}) > 64'h0000_0000_FFFF_FFFF;
      ss = sx + sy;
    end
    ov = (ss > 64'sd2147483647) || (ss < -64'sd2147483648);
  endfunction

  // Called at a negedge; returns at the first negedge after acceptance.
  task automatic start_op(input logic [31:0] x, input logic [31:0] y, input logic s);
    a     = x;
    b     = y;
    sel   = s;
    start = 1'b1;
    model(x, y, s, er, eco, eov);
    @(negedge clk);
    start = 1'b0;
    a     = $urandom;
    b     = $urandom;
    sel   = 1'($urandom_range(0, 1));
  endtask

  task automatic check_op(input string tag, input int nbusy);
    for (int i = 0; i < nbusy; i++) begin
      chk($sformatf("%s.busy%0d", tag, i), 32'(busy), 32'd1);
      chk($sformatf("%s.nodone%0d", tag, i), 32'(done), 32'd0);
      if (nbusy == N && i == 0) begin
        chk($sformatf("%s.clr_res", tag), result, 32'd0);
        chk($sformatf("%s.clr_cout", tag), 32'(c_out), 32'd0);
      end
      @(negedge clk);
    end
    chk($sformatf("%s.done", tag), 32'(done), 32'd1);
    chk($sformatf("%s.busy_lo", tag), 32'(busy), 32'd0);
    chk($sformatf("%s.result", tag), result, er);
    chk($sformatf("%s.c_out", tag), 32'(c_out), 32'(eco));
    chk($sformatf("%s.ovf", tag), 32'(overflow), 32'(eov));
  endtask

  task automatic idle_check(input string tag);
    @(negedge clk);
    chk($sformatf("%s.idle_done", tag), 32'(done), 32'd0);
    chk($sformatf("%s.idle_busy", tag), 32'(busy), 32'd0);
    chk($sformatf("%s.held", tag), result, er);
  endtask

  initial begin
    logic [31:0] x;
    logic [31:0] y;
    logic        s;
    rst_n = 1'b0;
    start = 1'b0;
    a     = '0;
    b     = '0;
    sel   = 1'b0;
    er    = '0;
    eco   = 1'b0;
    eov   = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst.busy", 32'(busy), 32'd0);
    chk("rst.done", 32'(done), 32'd0);
    chk("rst.result", result, 32'd0);
    chk("rst.c_out", 32'(c_out), 32'd0);
    chk("rst.ovf", 32'(overflow), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst.busy", 32'(busy), 32'd0);

    start_op(32'h0000_00FF, 32'h0000_0001, 1'b0); check_op("add_ff", N);   idle_check("add_ff");
    start_op(32'hFFFF_FFFF, 32'h0000_0001, 1'b0); check_op("add_wrap", N); idle_check("add_wrap");
    start_op(32'h7FFF_FFFF, 32'h0000_0001, 1'b0); check_op("add_ovf", N);  idle_check("add_ovf");
    start_op(32'd3, 32'd5, 1'b1);                 check_op("sub_3_5", N);  idle_check("sub_3_5");
    start_op(32'd5, 32'd3, 1'b1);                 check_op("sub_5_3", N);  idle_check("sub_5_3");
    start_op(32'h8000_0000, 32'd1, 1'b1);         check_op("sub_ovf", N);  idle_check("sub_ovf");

    // start pulsed during RUN must be ignored
    start_op(32'h1234_5678, 32'h0101_0101, 1'b0);
    chk("ign.busy0", 32'(busy), 32'd1);
    a     = $urandom;
    b     = $urandom;
    sel   = 1'b1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check_op("ign", N - 1);
    idle_check("ign");

    // back-to-back: new start issued in the DONE cycle
    start_op(32'hDEAD_BEEF, 32'h1111_1111, 1'b0);
    check_op("b2b1", N);
    start_op(32'h0000_0010, 32'h0000_0020, 1'b1);
    check_op("b2b2", N);
    idle_check("b2b2");

    // reset asserted during the second RUN cycle
    start_op(32'hAAAA_AAAA, 32'h5555_5555, 1'b0);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("midrst.busy", 32'(busy), 32'd0);
    chk("midrst.done", 32'(done), 32'd0);
    chk("midrst.result", result, 32'd0);
    chk("midrst.c_out", 32'(c_out), 32'd0);
    chk("midrst.ovf", 32'(overflow), 32'd0);
    for (int i = 0; i < N + 2; i++) begin
      @(negedge clk);
      chk($sformatf("midrst.nodone%0d", i), 32'(done), 32'd0);
    end
    start_op(32'h0F0F_0F0F, 32'hF0F0_F0F1, 1'b0); check_op("after_rst", N); idle_check("after_rst");

    for (int n = 0; n < 30; n++) begin
      x = $urandom;
      y = $urandom;
      case ($urandom_range(0, 3))
        0: x = 32'hFFFF_FFFF;
        1: y = x;
        default: ;
      endcase
      s = 1'($urandom_range(0, 1));
      start_op(x, y, s);
      check_op($sformatf("rnd%0d", n), N);
      if ($urandom_range(0, 1) == 1) idle_check($sformatf("rnd%0d", n));
    end
    idle_check("final");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
